// File: rtl/spi_eeprom_streamer.sv
`timescale 1ns/1ps
// spi_eeprom_streamer: SPI mode-0 sequential READ of an 8-bit-address EEPROM, streamed out over valid/ready
module spi_eeprom_streamer #(
  parameter int SCK_HALF       = 2,
  parameter int CS_HIGH_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] start_addr,
  input  logic       stop,
  output logic [7:0] byte_data,
  output logic [7:0] byte_addr,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       busy,
  output logic       spi_cs_n,
  output logic       spi_sck,
  output logic       spi_copi,
  input  logic       spi_cipo
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, HOLD, CS_HIGH} state_t;
  localparam logic [3:0] HM = 4'(SCK_HALF - 1);
  localparam logic [3:0] CM = 4'(CS_HIGH_CYCLES - 1);
  state_t state, state_d;
  logic [3:0] cnt, cnt_d;
  logic [2:0] bitc, bitc_d;
  logic [7:0] sr, sr_d, rx, rx_d, addr, addr_d, data_d, baddr_d;
  logic valid_d, sck_d, cs_n_d, copi_d;
  logic shifting, tick, rise, fall, last, accept, load;
  assign busy     = state != IDLE;
  assign shifting = state inside {CMD, ADDR, DATA};
  assign tick     = cnt == HM;
  assign rise     = shifting & ~spi_sck & tick;
  assign fall     = shifting & spi_sck & tick;
  assign last     = fall & (bitc == 3'd7);
  assign accept   = byte_valid & byte_ready;
  assign load     = (state == DATA && last && (!byte_valid || accept)) || (state == HOLD && accept);
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    bitc_d  = bitc;
    sr_d    = sr;
    rx_d    = rx;
    addr_d  = addr;
    data_d  = byte_data;
    baddr_d = byte_addr;
    valid_d = byte_valid;
    sck_d   = spi_sck;
    cs_n_d  = spi_cs_n;
    copi_d  = spi_copi;
    if (shifting) begin
      cnt_d = tick ? 4'd0 : cnt + 4'd1;
      sck_d = spi_sck ^ tick;
    end
    if (accept) valid_d = 1'b0;
    if (fall) bitc_d = bitc + 3'd1;
    if (fall && state != DATA) begin
      sr_d   = {sr[6:0], 1'b0};
      copi_d = sr[6];
    end
    if (rise && state == DATA) rx_d = {rx[6:0], spi_cipo};
    if (load) begin
      data_d  = rx;
      baddr_d = addr;
      valid_d = 1'b1;
      addr_d  = addr + 8'd1;
    end
    case (state)
      IDLE: if (start) begin
        state_d = CMD;
        cs_n_d  = 1'b0;
        addr_d  = start_addr;
        sr_d    = 8'h03;
        copi_d  = 1'b0;
        cnt_d   = 4'd0;
        bitc_d  = 3'd0;
        sck_d   = 1'b0;
      end
      CMD: if (last) begin
        state_d = ADDR;
        sr_d    = addr;
        copi_d  = addr[7];
      end
      ADDR: if (last) begin
        state_d = DATA;
        copi_d  = 1'b0;
      end
      DATA: if (last && !load) state_d = HOLD;
      HOLD: if (accept) begin
        state_d = DATA;
        cnt_d   = 4'd0;
      end
      CS_HIGH: begin
        cnt_d = cnt + 4'd1;
        if (cnt == CM) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (stop && state inside {CMD, ADDR, DATA, HOLD}) begin
      state_d = CS_HIGH;
      cs_n_d  = 1'b1;
      sck_d   = 1'b0;
      copi_d  = 1'b0;
      valid_d = 1'b0;
      cnt_d   = 4'd0;
      bitc_d  = 3'd0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      bitc       <= 3'd0;
      sr         <= 8'd0;
      rx         <= 8'd0;
      addr       <= 8'd0;
      byte_data  <= 8'd0;
      byte_addr  <= 8'd0;
      byte_valid <= 1'b0;
      spi_sck    <= 1'b0;
      spi_cs_n   <= 1'b1;
      spi_copi   <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      bitc       <= bitc_d;
      sr         <= sr_d;
      rx         <= rx_d;
      addr       <= addr_d;
      byte_data  <= data_d;
      byte_addr  <= baddr_d;
      byte_valid <= valid_d;
      spi_sck    <= sck_d;
      spi_cs_n   <= cs_n_d;
      spi_copi   <= copi_d;
    end
  end
endmodule
